// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - flash disk bus command encodings and controller states
package flash_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam int FLASH_MAX_NAME_WORDS = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NAME,
        ST_OPEN,
        ST_XFER,
        ST_EOF,
        ST_DONE
    } state_t;

endpackage

// File: rtl/flash_ctrl.sv
// rtl/flash_ctrl.sv - flash disk bus master sequencing name/open/data/eof phases
module flash_ctrl
    import flash_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             req,
    input  logic             req_wr,
    input  logic [159:0]     req_name,
    input  logic [2:0]       req_name_words,
    input  logic [LEN_W-1:0] req_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_be,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic [1:0]       m_cmd,
    output logic             d_qual,
    inout  wire  [31:0]      d_inout,
    output logic [3:0]       m_be,
    output logic             m_halt,
    output logic             m_eof,
    input  logic             s_halt
);

    state_t             state, next_state;
    logic               wr_q;
    logic [159:0]       name_q;
    logic [2:0]         nwords_q;
    logic [LEN_W-1:0]   len_q;
    logic [2:0]         idx;
    logic [LEN_W-1:0]   cnt;
    logic [31:0]        name_word;
    logic [31:0]        dout;
    logic               drive_en;
    logic               beat;
    logic               name_ok;
    logic [1:0]         cmd_sel;

    assign name_ok = (req_name_words != 3'd0) &&
                     (req_name_words <= 3'(FLASH_MAX_NAME_WORDS));
    assign beat    = (m_cmd != CMD_NOP) && !m_halt && !s_halt;
    assign d_inout = drive_en ? dout : 32'hzzzz_zzzz;

    // Direction comes straight from the request on the IDLE->NAME edge, before it is latched.
    assign cmd_sel = ((state == ST_IDLE) ? req_wr : wr_q) ? CMD_WRITE : CMD_READ;

    always_comb begin
        name_word = 32'd0;
        case (idx)
            3'd0: name_word = name_q[31:0];
            3'd1: name_word = name_q[63:32];
            3'd2: name_word = name_q[95:64];
            3'd3: name_word = name_q[127:96];
            3'd4: name_word = name_q[159:128];
            default: name_word = 32'd0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req) next_state = name_ok ? ST_NAME : ST_DONE;
            ST_NAME: if (beat && idx == nwords_q - 3'd1) next_state = ST_OPEN;
            ST_OPEN: if (beat) next_state = (len_q == '0) ? ST_EOF : ST_XFER;
            ST_XFER: if (beat && cnt == len_q - LEN_W'(1)) next_state = ST_EOF;
            ST_EOF:  if (beat) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        m_halt   = 1'b0;
        wr_ready = 1'b0;
        m_be     = 4'h0;
        dout     = 32'd0;
        drive_en = 1'b0;
        case (state)
            ST_NAME: begin
                m_be     = 4'hF;
                dout     = name_word;
                drive_en = 1'b1;
            end
            ST_OPEN, ST_EOF: drive_en = 1'b1;
            ST_XFER: begin
                if (wr_q) begin
                    m_be     = wr_be;
                    dout     = wr_data;
                    drive_en = 1'b1;
                    m_halt   = ~wr_valid | s_halt;
                    wr_ready = wr_valid & ~s_halt;
                end else begin
                    m_be   = 4'hF;
                    m_halt = s_halt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_q     <= 1'b0;
            name_q   <= '0;
            nwords_q <= 3'd0;
            len_q    <= '0;
            idx      <= 3'd0;
            cnt      <= '0;
            m_cmd    <= CMD_NOP;
            d_qual   <= 1'b0;
            m_eof    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rd_data  <= 32'd0;
            rd_valid <= 1'b0;
        end else begin
            state  <= next_state;
            m_cmd  <= (next_state inside {ST_NAME, ST_OPEN, ST_XFER, ST_EOF}) ? cmd_sel : CMD_NOP;
            d_qual <= (next_state == ST_NAME);
            m_eof  <= (next_state == ST_EOF);
            busy   <= (next_state != ST_IDLE);
            done   <= (next_state == ST_DONE);
            // Only a rejected request goes straight from IDLE to DONE.
            err    <= (next_state == ST_DONE) && (state == ST_IDLE);

            if (state == ST_IDLE && req) begin
                wr_q     <= req_wr;
                name_q   <= req_name;
                nwords_q <= req_name_words;
                len_q    <= req_len;
            end

            if (state == ST_IDLE)
                idx <= 3'd0;
            else if (state == ST_NAME && beat)
                idx <= idx + 3'd1;

            if (state == ST_IDLE)
                cnt <= '0;
            else if (state == ST_XFER && beat)
                cnt <= cnt + LEN_W'(1);

            rd_valid <= (state == ST_XFER) && !wr_q && beat;
            if ((state == ST_XFER) && !wr_q && beat)
                rd_data <= d_inout;
        end
    end

endmodule
